// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, decode and the branch logic.
// The master side is the fetch unit; the slave side is everything around it.
interface instr_fetch_unit_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             imemReqValid;
  logic             imemReqReady;
  logic [31:0]      imemAddr;
  logic             imemRspValid;
  logic [31:0]      imemRspData;
  logic             outValid;
  logic             outReady;
  logic [31:0]      instr;
  logic [5:0]       opcode;
  logic [31:0]      pcOut;
  logic [31:0]      pcPlus4;
  logic             branchTaken;
  logic [31:0]      branchTarget;
  logic [CNT_W-1:0] fetchCount;

  modport master (
    output imemReqValid,
    input  imemReqReady,
    output imemAddr,
    input  imemRspValid,
    input  imemRspData,
    output outValid,
    input  outReady,
    output instr,
    output opcode,
    output pcOut,
    output pcPlus4,
    input  branchTaken,
    input  branchTarget,
    output fetchCount
  );

  modport slave (
    input  imemReqValid,
    output imemReqReady,
    input  imemAddr,
    output imemRspValid,
    output imemRspData,
    input  outValid,
    output outReady,
    input  instr,
    input  opcode,
    input  pcOut,
    input  pcPlus4,
    output branchTaken,
    output branchTarget,
    input  fetchCount
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one memory request at a time, holds the
// returned word for decode and squashes wrong-path fetches on a branch redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e           state_q;
  logic [31:0]      pc_q;
  logic             drop_q;
  logic [31:0]      instr_q;
  logic [31:0]      pc_out_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      redirect_pc_s;
  logic [31:0]      pc_seq_s;
  logic             unused_s;

  assign redirect_pc_s = {bus.branchTarget[31:2], 2'b00};
  assign pc_seq_s      = pc_q + 32'd4;
  assign unused_s      = ^bus.branchTarget[1:0];

  // Fetch FSM plus PC, held instruction and delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_REQ;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      drop_q   <= 1'b0;
      instr_q  <= 32'h0000_0000;
      pc_out_q <= 32'h0000_0000;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (bus.branchTaken) begin
            pc_q <= redirect_pc_s;
            // A request accepted this edge still carries the old address.
            if (bus.imemReqReady) begin
              drop_q  <= 1'b1;
              state_q <= ST_WAIT;
            end
          end else if (bus.imemReqReady) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.branchTaken) begin
            pc_q <= redirect_pc_s;
            if (bus.imemRspValid) begin
              drop_q  <= 1'b0;
              state_q <= ST_REQ;
            end else begin
              drop_q  <= 1'b1;
            end
          end else if (bus.imemRspValid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= ST_REQ;
            end else begin
              instr_q  <= bus.imemRspData;
              pc_out_q <= pc_q;
              state_q  <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // A redirect squashes the held word even when decode is ready.
          if (bus.branchTaken) begin
            pc_q    <= redirect_pc_s;
            state_q <= ST_REQ;
          end else if (bus.outReady) begin
            pc_q    <= pc_seq_s;
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_REQ;
          end
        end
        default: begin
          state_q <= ST_REQ;
          drop_q  <= 1'b0;
        end
      endcase
    end
  end

  // Valids are forced low for the whole time reset_n is held low.
  assign bus.imemReqValid = reset_n & (state_q == ST_REQ);
  assign bus.outValid     = reset_n & (state_q == ST_HOLD);
  assign bus.imemAddr     = pc_q;
  assign bus.instr        = instr_q;
  assign bus.opcode       = instr_q[31:26];
  assign bus.pcOut        = pc_out_q;
  assign bus.pcPlus4      = pc_out_q + 32'd4;
  assign bus.fetchCount   = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model compared every cycle, a small memory
// model, directed redirect/reset scenarios, and a second instance for PC and counter wrap.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic rst_w_n;

  instr_fetch_unit_if #(.CNT_W(16)) bus ();
  instr_fetch_unit_if #(.CNT_W(2))  wbus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u_wrap (
    .clk(clk), .reset_n(rst_w_n), .bus(wbus));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pc, one outstanding request (possibly doomed), one held instruction.
  logic [31:0] m_pc, m_instr, m_pcout;
  logic [15:0] m_cnt;
  bit m_inflight, m_drop, m_held;
  bit m_known = 1'b0;

  // Memory model: one pending response, rsp_delay idle cycles after acceptance.
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;
  int          rsp_delay = 0;
  bit          force_rsp = 1'b0;
  logic [31:0] force_data = 32'h0;
  logic [31:0] acc_addrs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h8C22_0004;
    return {8'hE0, a[23:0]};
  endfunction

  task automatic compare_outputs();
    chk("imemReqValid", {31'h0, bus.imemReqValid},
        {31'h0, reset_n && m_known && !m_inflight && !m_held});
    chk("outValid", {31'h0, bus.outValid}, {31'h0, reset_n && m_known && m_held});
    if (m_known) begin
      chk("imemAddr", bus.imemAddr, m_pc);
      chk("instr", bus.instr, m_instr);
      chk("opcode", {26'h0, bus.opcode}, {26'h0, m_instr[31:26]});
      chk("pcOut", bus.pcOut, m_pcout);
      chk("pcPlus4", bus.pcPlus4, m_pcout + 32'd4);
      chk("fetchCount", {16'h0, bus.fetchCount}, {16'h0, m_cnt});
    end
  endtask

  task automatic model_update(input bit rv, input logic [31:0] rd);
    if (!reset_n) begin
      m_known = 1'b1; m_pc = 32'h0; m_inflight = 1'b0; m_drop = 1'b0;
      m_held = 1'b0; m_instr = 32'h0; m_pcout = 32'h0; m_cnt = 16'h0;
    end else if (bus.branchTaken) begin
      m_pc = {bus.branchTarget[31:2], 2'b00};
      if (m_held) m_held = 1'b0;
      else if (m_inflight) begin
        if (rv) begin m_inflight = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end else if (bus.imemReqReady) begin
        m_inflight = 1'b1; m_drop = 1'b1;
      end
    end else if (m_held) begin
      if (bus.outReady) begin m_pc = m_pc + 32'd4; m_cnt = m_cnt + 16'd1; m_held = 1'b0; end
    end else if (m_inflight) begin
      if (rv) begin
        m_inflight = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else begin m_held = 1'b1; m_instr = rd; m_pcout = m_pc; end
      end
    end else if (bus.imemReqReady) begin
      m_inflight = 1'b1;
    end
  endtask

  // One clock: drive response, compare at negedge, advance model and memory at posedge.
  task automatic step();
    bit rsp_v, acc;
    logic [31:0] rsp_d, addr;
    rsp_v = force_rsp || (mem_busy && mem_cnt == 0);
    rsp_d = force_rsp ? force_data : mem_word(mem_addr);
    bus.imemRspValid = rsp_v;
    bus.imemRspData  = rsp_d;
    @(negedge clk);
    compare_outputs();
    acc  = bus.imemReqValid && bus.imemReqReady;
    addr = bus.imemAddr;
    @(posedge clk);
    model_update(rsp_v, rsp_d);
    if (!reset_n) mem_busy = 1'b0;
    else begin
      if (rsp_v && !force_rsp) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (acc) begin
        mem_busy = 1'b1; mem_cnt = rsp_delay; mem_addr = addr;
        acc_addrs.push_back(addr);
      end
    end
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    rst_w_n = 1'b0;
    bus.imemReqReady = 1'b1; bus.outReady = 1'b1;
    bus.branchTaken = 1'b0;  bus.branchTarget = 32'h0;
    bus.imemRspValid = 1'b0; bus.imemRspData = 32'h0;
    wbus.imemReqReady = 1'b1; wbus.outReady = 1'b1;
    wbus.branchTaken = 1'b0;  wbus.branchTarget = 32'h0;
    wbus.imemRspValid = 1'b0; wbus.imemRspData = 32'h0;

    step(); step();
    reset_n = 1'b1;

    // Zero-wait streaming: three instructions from 0, 4, 8.
    acc_addrs.delete();
    repeat (9) step();
    chk("t1_count", {16'h0, bus.fetchCount}, 32'd3);
    chk("t1_nreq", acc_addrs.size(), 32'd3);
    chk("t1_addr0", acc_addrs.size() > 0 ? acc_addrs[0] : 32'hFFFF_FFFF, 32'h0);
    chk("t1_addr1", acc_addrs.size() > 1 ? acc_addrs[1] : 32'hFFFF_FFFF, 32'h4);
    chk("t1_addr2", acc_addrs.size() > 2 ? acc_addrs[2] : 32'hFFFF_FFFF, 32'h8);

    // Decode stalls on a held lw for five cycles.
    bus.outReady = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_outValid", {31'h0, bus.outValid}, 32'd1);
      chk("t2_opcode", {26'h0, bus.opcode}, 32'h23);
      chk("t2_count", {16'h0, bus.fetchCount}, 32'd3);
      chk("t2_pc", bus.imemAddr, 32'hC);
      step();
    end
    bus.outReady = 1'b1;
    step();
    chk("t2_count_after", {16'h0, bus.fetchCount}, 32'd4);

    // Redirect while waiting on a slow response: it must be dropped.
    rsp_delay = 2;
    step();
    bus.branchTaken = 1'b1; bus.branchTarget = 32'h0000_0043;
    step();
    bus.branchTaken = 1'b0;
    step();
    chk("t3_noout", {31'h0, bus.outValid}, 32'd0);
    step();
    chk("t3_noout2", {31'h0, bus.outValid}, 32'd0);
    chk("t3_req", {31'h0, bus.imemReqValid}, 32'd1);
    chk("t3_addr", bus.imemAddr, 32'h40);
    rsp_delay = 0;

    // Redirect in REQ without ready, then with ready (in-flight old request).
    bus.imemReqReady = 1'b0; bus.branchTaken = 1'b1; bus.branchTarget = 32'h100;
    step();
    bus.imemReqReady = 1'b1; bus.branchTaken = 1'b0;
    chk("t3b_addr", bus.imemAddr, 32'h100);
    bus.branchTaken = 1'b1; bus.branchTarget = 32'h203;
    step();
    bus.branchTaken = 1'b0;
    step();
    chk("t3c_addr", bus.imemAddr, 32'h200);
    chk("t3c_noout", {31'h0, bus.outValid}, 32'd0);

    // Redirect while holding with decode ready: squashed, not counted.
    step(); step();
    chk("t4_pcOut", bus.pcOut, 32'h200);
    bus.branchTaken = 1'b1; bus.branchTarget = 32'h300;
    step();
    bus.branchTaken = 1'b0;
    chk("t4_count", {16'h0, bus.fetchCount}, 32'd4);
    chk("t4_addr", bus.imemAddr, 32'h300);
    chk("t4_noout", {31'h0, bus.outValid}, 32'd0);

    // Redirect coinciding with the response in WAIT.
    step();
    bus.branchTaken = 1'b1; bus.branchTarget = 32'h400;
    step();
    bus.branchTaken = 1'b0;
    chk("t4b_addr", bus.imemAddr, 32'h400);
    repeat (3) step();
    chk("t4b_count", {16'h0, bus.fetchCount}, 32'd5);
    chk("t4b_addr2", bus.imemAddr, 32'h404);

    // Reset during WAIT; the late response that follows is ignored.
    rsp_delay = 1;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    force_rsp = 1'b1; force_data = 32'hDEAD_BEEF; bus.imemReqReady = 1'b0;
    step();
    chk("t6_req", {31'h0, bus.imemReqValid}, 32'd1);
    chk("t6_addr", bus.imemAddr, 32'h0);
    chk("t6_noout", {31'h0, bus.outValid}, 32'd0);
    chk("t6_instr", bus.instr, 32'h0);
    force_rsp = 1'b0; bus.imemReqReady = 1'b1; rsp_delay = 0;
    repeat (3) step();
    chk("t6_count", {16'h0, bus.fetchCount}, 32'd1);

    // Wrap instance: PC wraps past 0xFFFFFFFC, 2-bit counter wraps after four fires.
    rst_w_n = 1'b1;
    chk("t5_addr0", wbus.imemAddr, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      wbus.imemRspValid = 1'b1; wbus.imemRspData = 32'h0400_0000 | 32'(i);
      @(posedge clk); #1;
      wbus.imemRspValid = 1'b0;
      chk("t5_outValid", {31'h0, wbus.outValid}, 32'd1);
      chk("t5_opcode", {26'h0, wbus.opcode}, 32'h1);
      chk("t5_pcOut", wbus.pcOut, 32'hFFFF_FFFC + 32'(4 * i));
      chk("t5_pcPlus4", wbus.pcPlus4, 32'(4 * i));
      @(posedge clk); #1;
      if (i == 0) chk("t5_addr_wrap", wbus.imemAddr, 32'h0);
    end
    chk("t5_addr_end", wbus.imemAddr, 32'hC);
    chk("t5_count_wrap", {30'h0, wbus.fetchCount}, 32'd0);
    chk("t5_req", {31'h0, wbus.imemReqValid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
